onedconv_ddr_stream_mover: RTL and testbench

//  Data mover between the DDR-side AXI-Stream DMA and the 1D-conv BRAM banks. It services the

---
 rtl/onedconv_ddr_stream_mover.sv | 206 ++++++++++++++++++++
 tb/tb_onedconv_ddr_stream_mover.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onedconv_ddr_stream_mover.sv
// Moves DDR AXI-Stream data into the weight/ifmap BRAM banks (round-robin scatter) and gathers ofmap banks out.
// Latency: inbound BRAM write in the same cycle as the beat; first outbound tvalid 2 cycles after entering OUT_XFER.
// Backpressure: s_axis_tready only in IN_XFER; outbound 2-entry skid FIFO holds data stable while m_axis_tready=0.
module onedconv_ddr_stream_mover #(
    parameter int DW             = 16,
    parameter int Dimension      = 16,
    parameter int ADDRESS_LENGTH = 10,
    parameter int LEN_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      weight_read_req,
    input  logic                      ifmap_read_req,
    input  logic                      ofmap_write_req,
    input  logic [LEN_W-1:0]          weight_len,
    input  logic [LEN_W-1:0]          ifmap_len,
    input  logic [LEN_W-1:0]          ofmap_len,
    input  logic [DW-1:0]             s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DW-1:0]             m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [ADDRESS_LENGTH-1:0] wr_addr,
    output logic [DW-1:0]             wr_data,
    output logic [Dimension-1:0]      wea_weight,
    output logic [Dimension-1:0]      wea_ifmap,
    output logic [ADDRESS_LENGTH-1:0] rd_addr,
    output logic [Dimension-1:0]      enb_ofmap,
    input  logic [DW*Dimension-1:0]   ofmap_rd_data,
    output logic                      write_done,
    output logic                      read_done,
    output logic                      busy,
    output logic                      err_tlast
);

    localparam int BW = $clog2(Dimension);

    typedef enum logic [1:0] {IDLE, IN_XFER, OUT_XFER, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;        // beats written (inbound) or words sent (outbound)
    logic [LEN_W-1:0] issued;     // outbound BRAM reads issued
    logic             dest_weight;
    logic             weight_pend;
    logic             ifmap_pend;
    logic             ofmap_pend;

    logic             grant_w;
    logic             grant_i;
    logic             grant_o;
    logic [LEN_W-1:0] start_len;

    logic             in_beat;
    logic             last_word;
    logic             out_issue;
    logic             out_pop;
    logic [1:0]       occ_after;

    logic             inflight;   // a BRAM read issued last cycle; its data is on ofmap_rd_data now
    logic [BW-1:0]    sel_r;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;

    // Fixed-priority grant of pending requests, only while idle.
    always_comb begin
        grant_w   = 1'b0;
        grant_i   = 1'b0;
        grant_o   = 1'b0;
        if (state == IDLE) begin
            grant_w = weight_pend;
            grant_i = ifmap_pend & ~weight_pend;
            grant_o = ofmap_pend & ~weight_pend & ~ifmap_pend;
        end
        start_len = grant_w ? weight_len : (grant_i ? ifmap_len : ofmap_len);
    end

    // Inbound scatter: beat i goes to bank i mod Dimension at row i / Dimension, written combinationally.
    assign s_axis_tready = (state == IN_XFER);
    assign in_beat       = s_axis_tready & s_axis_tvalid;
    assign last_word     = (cnt == len_r - LEN_W'(1));
    assign wea_weight    = (in_beat &&  dest_weight) ? (Dimension'(1) << cnt[BW-1:0]) : '0;
    assign wea_ifmap     = (in_beat && !dest_weight) ? (Dimension'(1) << cnt[BW-1:0]) : '0;
    assign wr_addr       = in_beat ? ADDRESS_LENGTH'(cnt >> BW) : '0;
    assign wr_data       = in_beat ? s_axis_tdata : '0;

    // Outbound gather: a read is only issued if its data is guaranteed a FIFO slot after this cycle's pop.
    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign out_pop       = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid & last_word;
    assign occ_after     = fifo_count + {1'b0, inflight} - {1'b0, out_pop};
    assign out_issue     = (state == OUT_XFER) && (issued < len_r) && (occ_after < 2'd2);
    assign enb_ofmap     = out_issue ? (Dimension'(1) << issued[BW-1:0]) : '0;
    assign rd_addr       = out_issue ? ADDRESS_LENGTH'(issued >> BW) : '0;
    assign rd_word       = ofmap_rd_data[sel_r*DW +: DW];

    // Read-return pipeline and 2-entry skid FIFO feeding m_axis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            sel_r       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight <= out_issue;
            if (out_issue) begin
                sel_r <= issued[BW-1:0];
            end
            if (inflight) begin
                fifo_mem[wr_ptr] <= rd_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (out_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, out_pop};
        end
    end

    // Control FSM: request latching, transfer sequencing, registered done/busy/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_r       <= '0;
            cnt         <= '0;
            issued      <= '0;
            dest_weight <= 1'b0;
            weight_pend <= 1'b0;
            ifmap_pend  <= 1'b0;
            ofmap_pend  <= 1'b0;
            busy        <= 1'b0;
            write_done  <= 1'b0;
            read_done   <= 1'b0;
            err_tlast   <= 1'b0;
        end else begin
            write_done  <= 1'b0;
            read_done   <= 1'b0;
            // A repeat pulse while the latch is set (including the grant cycle) is absorbed.
            weight_pend <= grant_w ? 1'b0 : (weight_pend | weight_read_req);
            ifmap_pend  <= grant_i ? 1'b0 : (ifmap_pend  | ifmap_read_req);
            ofmap_pend  <= grant_o ? 1'b0 : (ofmap_pend  | ofmap_write_req);
            case (state)
                IDLE: begin
                    if (grant_w | grant_i | grant_o) begin
                        len_r       <= start_len;
                        cnt         <= '0;
                        issued      <= '0;
                        dest_weight <= grant_w;
                        busy        <= 1'b1;
                        if (start_len == '0) begin
                            state      <= DONE;
                            write_done <= ~grant_o;
                            read_done  <= grant_o;
                        end else begin
                            state <= grant_o ? OUT_XFER : IN_XFER;
                        end
                    end
                end
                IN_XFER: begin
                    if (in_beat) begin
                        cnt <= cnt + LEN_W'(1);
                        // Either the count or tlast ends the transfer; disagreement flags an error.
                        if (last_word || s_axis_tlast) begin
                            if (last_word != s_axis_tlast) begin
                                err_tlast <= 1'b1;
                            end
                            state      <= DONE;
                            write_done <= 1'b1;
                        end
                    end
                end
                OUT_XFER: begin
                    if (out_issue) begin
                        issued <= issued + LEN_W'(1);
                    end
                    if (out_pop) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_word) begin
                            state     <= DONE;
                            read_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onedconv_ddr_stream_mover.sv
// Bench for onedconv_ddr_stream_mover: table of transfers plus hand sequences for len=0, simultaneous requests, mid-transfer reset.
// Inbound writes and outbound words are checked against queues filled when stimulus is driven.
// Outbound sink applies always-ready or alternating m_axis_tready.
module tb_onedconv_ddr_stream_mover;

    localparam int DW  = 16;
    localparam int DIM = 16;
    localparam int AL  = 10;
    localparam int LW  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              weight_read_req = 1'b0;
    logic              ifmap_read_req = 1'b0;
    logic              ofmap_write_req = 1'b0;
    logic [LW-1:0]     weight_len = '0;
    logic [LW-1:0]     ifmap_len = '0;
    logic [LW-1:0]     ofmap_len = '0;
    logic [DW-1:0]     s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [AL-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DIM-1:0]    wea_weight;
    logic [DIM-1:0]    wea_ifmap;
    logic [AL-1:0]     rd_addr;
    logic [DIM-1:0]    enb_ofmap;
    logic [DW*DIM-1:0] ofmap_rd_data = '0;
    logic              write_done;
    logic              read_done;
    logic              busy;
    logic              err_tlast;

    always #5 clk = ~clk;

    onedconv_ddr_stream_mover #(
        .DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AL), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .weight_read_req(weight_read_req), .ifmap_read_req(ifmap_read_req), .ofmap_write_req(ofmap_write_req),
        .weight_len(weight_len), .ifmap_len(ifmap_len), .ofmap_len(ofmap_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wea_weight(wea_weight), .wea_ifmap(wea_ifmap),
        .rd_addr(rd_addr), .enb_ofmap(enb_ofmap), .ofmap_rd_data(ofmap_rd_data),
        .write_done(write_done), .read_done(read_done), .busy(busy), .err_tlast(err_tlast)
    );

    typedef struct { logic [DIM-1:0] ww; logic [DIM-1:0] wi; logic [AL-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; logic last; } out_t;
    // dir: 0 weight, 1 ifmap, 2 ofmap; tl = beat carrying tlast (-1 none); nb = beats the source offers
    typedef struct { int dir; int len; int tl; int nb; bit tog; bit rst; bit exp_err; } vec_t;

    wr_t  in_q[$];
    out_t out_q[$];
    wr_t  e_wr;
    out_t e_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wd_cnt = 0, rd_cnt = 0, enb_cnt = 0;
    int wd_cyc = 0, rd_cyc = 0, last_wr_cyc = 0, busy_rise_cyc = 0, tv_rise_cyc = 0, last_pop_cyc = 0;
    logic busy_q = 1'b0;
    logic tv_armed = 1'b0;
    logic hold_vld = 1'b0;
    logic [DW-1:0] hold_dat = '0;
    logic toggle_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bram_val(input int k, input int a);
        return DW'((k * 4369) ^ (a * 37) ^ 23040);
    endfunction

    always @(posedge clk) cyc++;

    // ofmap BRAM model: 1-cycle read latency per enabled bank
    always @(posedge clk) begin
        for (int k = 0; k < DIM; k++) begin
            if (enb_ofmap[k]) ofmap_rd_data[k*DW +: DW] <= bram_val(k, int'(rd_addr));
        end
    end

    // outbound sink readiness
    always @(posedge clk) begin
        #1;
        m_axis_tready = toggle_mode ? ~m_axis_tready : 1'b1;
    end

    // monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (write_done) begin wd_cnt++; wd_cyc = cyc; end
        if (read_done)  begin rd_cnt++; rd_cyc = cyc; end
        if (busy && !busy_q) begin busy_rise_cyc = cyc; tv_armed = 1'b1; end
        busy_q = busy;
        if (m_axis_tvalid && tv_armed) begin tv_rise_cyc = cyc; tv_armed = 1'b0; end
        if (enb_ofmap != '0) begin
            enb_cnt++;
            check("enb_onehot", $countones(enb_ofmap), 1);
        end
        if (wea_weight != '0 || wea_ifmap != '0) begin
            last_wr_cyc = cyc;
            check("write_expected", in_q.size() != 0, 1);
            if (in_q.size() != 0) begin
                e_wr = in_q.pop_front();
                check("wea_weight", wea_weight, e_wr.ww);
                check("wea_ifmap", wea_ifmap, e_wr.wi);
                check("wr_addr", wr_addr, e_wr.addr);
                check("wr_data", wr_data, e_wr.data);
            end
        end
        if (hold_vld) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, hold_dat);
        end
        hold_vld = m_axis_tvalid && !m_axis_tready;
        hold_dat = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            last_pop_cyc = cyc;
            check("out_expected", out_q.size() != 0, 1);
            if (out_q.size() != 0) begin
                e_out = out_q.pop_front();
                check("m_axis_tdata", m_axis_tdata, e_out.data);
                check("m_axis_tlast", m_axis_tlast, e_out.last);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs_zero", |{s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, wr_addr, wr_data,
              wea_weight, wea_ifmap, rd_addr, enb_ofmap, write_done, read_done, busy, err_tlast}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_beats(input bit is_w, input int n, input int tl);
        int t;
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.data = DW'($urandom);
            w.ww   = is_w ? (DIM'(1) << (i % DIM)) : '0;
            w.wi   = is_w ? '0 : (DIM'(1) << (i % DIM));
            w.addr = AL'(i / DIM);
            in_q.push_back(w);
            s_axis_tdata  = w.data;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == tl);
            t = 0;
            @(negedge clk);
            while (!s_axis_tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("beat%0d_accepted", i), s_axis_tready, 1);
            if (!s_axis_tready) break;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (wd_cnt + rd_cnt < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", wd_cnt + rd_cnt >= target, 1);
    endtask

    task automatic push_out(input int len);
        out_t e;
        for (int i = 0; i < len; i++) begin
            e.data = bram_val(i % DIM, i / DIM);
            e.last = (i == len - 1);
            out_q.push_back(e);
        end
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int wd0, rd0, en0;
        if (v.rst) do_reset();
        wd0 = wd_cnt; rd0 = rd_cnt; en0 = enb_cnt;
        toggle_mode = v.tog;
        if (v.dir == 2) begin
            push_out(v.len);
            ofmap_len = LW'(v.len);
            ofmap_write_req = 1'b1;
            @(posedge clk); #1;
            ofmap_write_req = 1'b0;
        end else begin
            if (v.dir == 0) begin weight_len = LW'(v.len); weight_read_req = 1'b1; end
            else            begin ifmap_len  = LW'(v.len); ifmap_read_req  = 1'b1; end
            @(posedge clk); #1;
            weight_read_req = 1'b0;
            ifmap_read_req  = 1'b0;
            send_beats(v.dir == 0, v.nb, v.tl);
        end
        wait_done(wd0 + rd0 + 1);
        repeat (3) @(posedge clk);
        #1;
        toggle_mode = 1'b0;
        check($sformatf("c%0d_err_tlast", idx), err_tlast, v.exp_err);
        check($sformatf("c%0d_write_done_count", idx), wd_cnt - wd0, (v.dir != 2) ? 1 : 0);
        check($sformatf("c%0d_read_done_count", idx), rd_cnt - rd0, (v.dir == 2) ? 1 : 0);
        check($sformatf("c%0d_writes_left", idx), in_q.size(), 0);
        check($sformatf("c%0d_words_left", idx), out_q.size(), 0);
        check($sformatf("c%0d_read_enables", idx), enb_cnt - en0, (v.dir == 2) ? v.len : 0);
        check($sformatf("c%0d_busy_after", idx), busy, 0);
        if (v.dir == 2) begin
            check($sformatf("c%0d_first_tvalid_latency", idx), tv_rise_cyc - busy_rise_cyc, 2);
            if (!v.tog) check($sformatf("c%0d_out_throughput", idx), last_pop_cyc - tv_rise_cyc, v.len - 1);
        end else begin
            check($sformatf("c%0d_done_after_last_beat", idx), wd_cyc - last_wr_cyc, 1);
        end
        in_q.delete();
        out_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wd0, rd0, en0;
        vecs[0] = '{0, 40, 39, 40, 0, 0, 0};   // weight, tlast on last beat
        vecs[1] = '{2, 33, -1, 0, 1, 0, 0};    // ofmap, alternating tready
        vecs[2] = '{1, 17, 16, 17, 0, 0, 0};   // ifmap, crosses a row
        vecs[3] = '{2, 5, -1, 0, 0, 0, 0};     // ofmap, full-rate sink
        vecs[4] = '{0, 4, -1, 4, 0, 0, 1};     // weight, tlast missing on last beat
        vecs[5] = '{1, 8, 5, 6, 0, 1, 1};      // ifmap after reset, tlast early on beat 5

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero_init", |{s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, wr_addr, wr_data,
              wea_weight, wea_ifmap, rd_addr, enb_ofmap, write_done, read_done, busy, err_tlast}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_tready", s_axis_tready, 0);

        for (int i = 0; i < 6; i++) run_case(i, vecs[i]);

        // zero-length requests: done two cycles after the pulse, no enables
        wd0 = wd_cnt; rd0 = rd_cnt; en0 = enb_cnt;
        ifmap_len = '0;
        ifmap_read_req = 1'b1;
        @(posedge clk); #1;
        ifmap_read_req = 1'b0;
        @(negedge clk);
        check("len0_no_early_done", write_done, 0);
        @(negedge clk);
        check("len0_done_2_cycles", write_done, 1);
        ofmap_len = '0;
        ofmap_write_req = 1'b1;
        @(posedge clk); #1;
        ofmap_write_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("len0_write_done_count", wd_cnt - wd0, 1);
        check("len0_read_done_count", rd_cnt - rd0, 1);
        check("len0_no_read_enables", enb_cnt - en0, 0);

        // simultaneous weight and ofmap requests: weight first
        wd0 = wd_cnt; rd0 = rd_cnt;
        weight_len = LW'(20);
        ofmap_len  = LW'(18);
        push_out(18);
        weight_read_req = 1'b1;
        ofmap_write_req = 1'b1;
        @(posedge clk); #1;
        weight_read_req = 1'b0;
        ofmap_write_req = 1'b0;
        send_beats(1'b1, 20, 19);
        wait_done(wd0 + rd0 + 2);
        repeat (3) @(posedge clk);
        #1;
        check("simul_write_done_count", wd_cnt - wd0, 1);
        check("simul_read_done_count", rd_cnt - rd0, 1);
        check("simul_weight_before_ofmap", wd_cyc < rd_cyc, 1);
        check("simul_words_left", out_q.size(), 0);
        in_q.delete();
        out_q.delete();

        // reset at beat 10 of a 40-beat transfer, with an ifmap request pending
        wd0 = wd_cnt; rd0 = rd_cnt;
        weight_len = LW'(40);
        ifmap_len  = LW'(3);
        weight_read_req = 1'b1;
        @(posedge clk); #1;
        weight_read_req = 1'b0;
        ifmap_read_req  = 1'b1;
        @(posedge clk); #1;
        ifmap_read_req  = 1'b0;
        send_beats(1'b1, 10, -1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hBEEF;
        do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", (wd_cnt - wd0) + (rd_cnt - rd0), 0);
        check("abort_pending_cleared", busy, 0);
        check("abort_writes_left", in_q.size(), 0);
        weight_len = LW'(5);
        weight_read_req = 1'b1;
        @(posedge clk); #1;
        weight_read_req = 1'b0;
        send_beats(1'b1, 5, 4);
        wait_done(wd0 + rd0 + 1);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_write_done", wd_cnt - wd0, 1);
        check("post_reset_err_tlast", err_tlast, 0);
        check("post_reset_writes_left", in_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
